// File: rtl/score_text_writer.sv
// rtl/score_text_writer.sv - game-over character map with a live 4-digit decimal score field
// Binary score is converted by repeated subtraction; digits commit together so reads never see partial values.
module score_text_writer #(
    parameter int SCORE_W   = 14,
    parameter int MAX_SCORE = 9999
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [SCORE_W-1:0] score,
    output logic               busy,
    output logic               done,
    input  logic [7:0]         char_yx,
    output logic [6:0]         char_code
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_THOUS,
        S_HUND,
        S_TENS,
        S_COMMIT
    } state_t;

    localparam logic [SCORE_W-1:0] LP_MAX_IN  = SCORE_W'(MAX_SCORE);
    localparam logic [13:0]        LP_MAX_REM = 14'(MAX_SCORE);
    localparam logic [6:0]         LP_BLANK   = 7'h00;

    state_t      r_state;
    state_t      w_next;
    logic [13:0] r_rem;
    logic [3:0]  r_q3;
    logic [3:0]  r_q2;
    logic [3:0]  r_q1;
    logic [6:0]  r_d3;
    logic [6:0]  r_d2;
    logic [6:0]  r_d1;
    logic [6:0]  r_d0;
    logic        r_busy;
    logic        r_done;
    logic [6:0]  r_char_code;

    logic [13:0] w_weight;
    logic        w_ge;
    logic [13:0] w_diff;
    logic [13:0] w_sat;
    logic        w_accept;
    logic        w_step;
    logic        w_commit;
    logic [6:0]  w_d3;
    logic [6:0]  w_d2;
    logic [6:0]  w_d1;
    logic [6:0]  w_d0;
    logic [6:0]  w_char;

    assign w_sat = (score > LP_MAX_IN) ? LP_MAX_REM : 14'(score);

    always_comb begin
        w_weight = 14'd10;
        case (r_state)
            S_THOUS: w_weight = 14'd1000;
            S_HUND:  w_weight = 14'd100;
            default: w_weight = 14'd10;
        endcase
    end

    assign w_ge   = (r_rem >= w_weight);
    assign w_diff = r_rem - w_weight;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next   = r_state;
        w_accept = 1'b0;
        w_step   = 1'b0;
        w_commit = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_accept = 1'b1;
                    w_next   = S_THOUS;
                end
            end
            S_THOUS: begin
                if (w_ge) begin
                    w_step = 1'b1;
                end else begin
                    w_next = S_HUND;
                end
            end
            S_HUND: begin
                if (w_ge) begin
                    w_step = 1'b1;
                end else begin
                    w_next = S_TENS;
                end
            end
            S_TENS: begin
                if (w_ge) begin
                    w_step = 1'b1;
                end else begin
                    w_next = S_COMMIT;
                end
            end
            S_COMMIT: begin
                w_commit = 1'b1;
                w_next   = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Positions above the most significant nonzero digit are blanked; ones is always a numeral.
    assign w_d3 = (r_q3 == 4'd0) ? LP_BLANK : {3'b011, r_q3};
    assign w_d2 = ((r_q3 == 4'd0) && (r_q2 == 4'd0)) ? LP_BLANK : {3'b011, r_q2};
    assign w_d1 = ((r_q3 == 4'd0) && (r_q2 == 4'd0) && (r_q1 == 4'd0)) ? LP_BLANK
                                                                        : {3'b011, r_q1};
    assign w_d0 = {3'b011, r_rem[3:0]};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rem  <= 14'd0;
            r_q3   <= 4'd0;
            r_q2   <= 4'd0;
            r_q1   <= 4'd0;
            r_busy <= 1'b0;
            r_done <= 1'b0;
            r_d3   <= LP_BLANK;
            r_d2   <= LP_BLANK;
            r_d1   <= LP_BLANK;
            r_d0   <= 7'h30;
        end else begin
            r_done <= w_commit;
            if (w_accept) begin
                r_rem  <= w_sat;
                r_q3   <= 4'd0;
                r_q2   <= 4'd0;
                r_q1   <= 4'd0;
                r_busy <= 1'b1;
            end
            if (w_step) begin
                r_rem <= w_diff;
                case (r_state)
                    S_THOUS: r_q3 <= r_q3 + 4'd1;
                    S_HUND:  r_q2 <= r_q2 + 4'd1;
                    default: r_q1 <= r_q1 + 4'd1;
                endcase
            end
            if (w_commit) begin
                r_d3   <= w_d3;
                r_d2   <= w_d2;
                r_d1   <= w_d1;
                r_d0   <= w_d0;
                r_busy <= 1'b0;
            end
        end
    end

    always_comb begin
        w_char = LP_BLANK;
        case (char_yx)
            8'h24:   w_char = 7'h47;
            8'h25:   w_char = 7'h41;
            8'h26:   w_char = 7'h4D;
            8'h27:   w_char = 7'h45;
            8'h29:   w_char = 7'h4F;
            8'h2A:   w_char = 7'h56;
            8'h2B:   w_char = 7'h45;
            8'h2C:   w_char = 7'h52;
            8'h45:   w_char = 7'h53;
            8'h46:   w_char = 7'h63;
            8'h47:   w_char = 7'h6F;
            8'h48:   w_char = 7'h72;
            8'h49:   w_char = 7'h65;
            8'h4A:   w_char = 7'h3A;
            8'h4C:   w_char = r_d3;
            8'h4D:   w_char = r_d2;
            8'h4E:   w_char = r_d1;
            8'h4F:   w_char = r_d0;
            default: w_char = LP_BLANK;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_char_code <= LP_BLANK;
        end else begin
            r_char_code <= w_char;
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign char_code = r_char_code;

endmodule

// File: tb/tb_score_text_writer.sv
// tb/tb_score_text_writer.sv - directed self-checking bench for score_text_writer
module tb_score_text_writer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [13:0] score;
    logic        busy;
    logic        done;
    logic [7:0]  char_yx;
    logic [6:0]  char_code;

    int checks = 0;
    int errors = 0;

    logic [6:0] cur_field [4];

    typedef struct {
        logic [7:0] addr;
        logic [6:0] code;
    } text_vec_t;

    typedef struct {
        logic [13:0] score;
        logic [27:0] digits;
        int          lat;
    } conv_vec_t;

    score_text_writer #(.SCORE_W(14), .MAX_SCORE(9999)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .score     (score),
        .busy      (busy),
        .done      (done),
        .char_yx   (char_yx),
        .char_code (char_code)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [6:0] model_char(input logic [7:0] a);
        case (a)
            8'h24: return 7'h47;
            8'h25: return 7'h41;
            8'h26: return 7'h4D;
            8'h27: return 7'h45;
            8'h29: return 7'h4F;
            8'h2A: return 7'h56;
            8'h2B: return 7'h45;
            8'h2C: return 7'h52;
            8'h45: return 7'h53;
            8'h46: return 7'h63;
            8'h47: return 7'h6F;
            8'h48: return 7'h72;
            8'h49: return 7'h65;
            8'h4A: return 7'h3A;
            8'h4C: return cur_field[0];
            8'h4D: return cur_field[1];
            8'h4E: return cur_field[2];
            8'h4F: return cur_field[3];
            default: return 7'h00;
        endcase
    endfunction

    task automatic read_char(input logic [7:0] a, output logic [6:0] c);
        @(negedge clk);
        char_yx = a;
        @(negedge clk);
        c = char_code;
    endtask

    task automatic check_field(input string name, input logic [27:0] exp_d);
        logic [6:0] c;
        for (int k = 0; k < 4; k++) begin
            read_char(8'h4C + 8'(k), c);
            check(name, 32'(c), 32'(exp_d[27 - 7*k -: 7]));
        end
    endtask

    // Watches the score field on every cycle of the conversion; it must hold its old value up to done.
    task automatic run_conv(input logic [13:0] s, input logic [27:0] exp_d, input int exp_lat,
                            input int restart_at, input logic [13:0] alt);
        int         n;
        bit         seen;
        logic [7:0] prev;
        @(negedge clk);
        start   = 1'b1;
        score   = s;
        char_yx = 8'h4C;
        prev    = 8'h4C;
        @(negedge clk);
        start = 1'b0;
        check("busy_after_accept", 32'(busy), 32'd1);
        check("field_hold", 32'(char_code), 32'(model_char(prev)));
        prev    = 8'h4D;
        char_yx = prev;
        n    = 0;
        seen = 1'b0;
        while (!seen && n < 40) begin
            @(negedge clk);
            n++;
            check("field_hold", 32'(char_code), 32'(model_char(prev)));
            prev    = 8'h4C + 8'(n % 4);
            char_yx = prev;
            if (done) seen = 1'b1;
            else check("busy_during", 32'(busy), 32'd1);
            start = (n == restart_at);
            score = (n == restart_at) ? alt : s;
        end
        start = 1'b0;
        if (!seen) begin
            check("done_timeout", 32'd0, 32'd1);
        end else begin
            check("latency", 32'(n), 32'(exp_lat));
            check("busy_at_done", 32'(busy), 32'd0);
        end
        for (int k = 0; k < 4; k++) cur_field[k] = exp_d[27 - 7*k -: 7];
        @(negedge clk);
        check("done_one_cycle", 32'(done), 32'd0);
        check("idle_after_done", 32'(busy), 32'd0);
        check_field("digits", exp_d);
    endtask

    initial begin
        text_vec_t  tv [8];
        conv_vec_t  cv [11];
        logic [6:0] c;
        logic [7:0] prev;

        tv[0] = '{8'h24, 7'h47};
        tv[1] = '{8'h28, 7'h00};
        tv[2] = '{8'h2C, 7'h52};
        tv[3] = '{8'h4A, 7'h3A};
        tv[4] = '{8'h45, 7'h53};
        tv[5] = '{8'h4B, 7'h00};
        tv[6] = '{8'hFF, 7'h00};
        tv[7] = '{8'h70, 7'h00};

        cv[0]  = '{14'd42,    {7'h00, 7'h00, 7'h34, 7'h32}, 8};
        cv[1]  = '{14'd12345, {7'h39, 7'h39, 7'h39, 7'h39}, 31};
        cv[2]  = '{14'd0,     {7'h00, 7'h00, 7'h00, 7'h30}, 4};
        cv[3]  = '{14'd1005,  {7'h31, 7'h30, 7'h30, 7'h35}, 5};
        cv[4]  = '{14'd9999,  {7'h39, 7'h39, 7'h39, 7'h39}, 31};
        cv[5]  = '{14'd7,     {7'h00, 7'h00, 7'h00, 7'h37}, 4};
        cv[6]  = '{14'd10000, {7'h39, 7'h39, 7'h39, 7'h39}, 31};
        cv[7]  = '{14'd90,    {7'h00, 7'h00, 7'h39, 7'h30}, 13};
        cv[8]  = '{14'd100,   {7'h00, 7'h31, 7'h30, 7'h30}, 5};
        cv[9]  = '{14'd16383, {7'h39, 7'h39, 7'h39, 7'h39}, 31};
        cv[10] = '{14'd1000,  {7'h31, 7'h30, 7'h30, 7'h30}, 5};

        cur_field[0] = 7'h00;
        cur_field[1] = 7'h00;
        cur_field[2] = 7'h00;
        cur_field[3] = 7'h30;

        rst     = 1'b1;
        start   = 1'b0;
        score   = 14'd0;
        char_yx = 8'h4F;
        repeat (2) @(negedge clk);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        check("reset_char_code", 32'(char_code), 32'd0);
        rst = 1'b0;
        check_field("reset_field", {7'h00, 7'h00, 7'h00, 7'h30});

        for (int i = 0; i < 8; i++) begin
            read_char(tv[i].addr, c);
            check("text", 32'(c), 32'(tv[i].code));
        end

        @(negedge clk);
        char_yx = 8'h00;
        prev    = 8'h00;
        for (int i = 1; i <= 256; i++) begin
            @(negedge clk);
            check("sweep", {24'(prev), 1'b0, char_code}, {24'(prev), 1'b0, model_char(prev)});
            if (i < 256) begin
                prev    = 8'(i);
                char_yx = prev;
            end
        end

        for (int i = 0; i < 11; i++) begin
            run_conv(cv[i].score, cv[i].digits, cv[i].lat, 0, 14'd0);
        end

        run_conv(14'd42, {7'h00, 7'h00, 7'h34, 7'h32}, 8, 3, 14'd777);
        run_conv(14'd42, {7'h00, 7'h00, 7'h34, 7'h32}, 8, 7, 14'd5);

        // 5300: THOUS occupies edges 1-6, HUND is entered on edge 6 and still active after edge 7.
        @(negedge clk);
        start = 1'b1;
        score = 14'd5300;
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        check("busy_in_hund", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_char_code", 32'(char_code), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        cur_field[0] = 7'h00;
        cur_field[1] = 7'h00;
        cur_field[2] = 7'h00;
        cur_field[3] = 7'h30;
        check_field("abort_field", {7'h00, 7'h00, 7'h00, 7'h30});
        check("abort_idle", 32'(busy), 32'd0);

        run_conv(14'd305, {7'h00, 7'h33, 7'h30, 7'h35}, 7, 0, 14'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
